// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015) cipher core:
// S-box table, FSM state type, round-key selection and the round function g.
package magma_pkg;

    localparam int ROUNDS = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} magma_state_e;

    // Each row is one pi box; the output for input nibble n sits at bits [4n+3:4n].
    localparam logic [63:0] MAGMA_PI [8] = '{
        64'h1F30_7D8E_9B5A_264C,
        64'hF0DB_74E1_C5A9_3286,
        64'h069C_471E_DAF2_853B,
        64'hB9E3_5A07_6F4D_128C,
        64'hC24B_E390_D618_A5F7,
        64'h0E34_187B_AC29_6FD5,
        64'h73AD_0B4F_C196_52E8,
        64'h2BC9_6AF4_3850_DE71
    };

    // Zero-based key word index (0 = K1 = key[255:224]) used in a given round.
    function automatic logic [2:0] magma_key_idx(input logic [4:0] round, input logic decrypt);
        logic [4:0] fwd_rounds;
        fwd_rounds = decrypt ? 5'd8 : 5'd24;
        return (round < fwd_rounds) ? round[2:0] : (3'd7 - round[2:0]);
    endfunction

    function automatic logic [31:0] magma_g(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] s;
        logic [31:0] t;
        logic [63:0] row;
        s = x + k;
        t = '0;
        for (int n = 0; n < 8; n++) begin
            row = MAGMA_PI[n];
            t[4*n +: 4] = row[{s[4*n +: 4], 2'b00} +: 4];
        end
        return {t[20:0], t[31:21]};
    endfunction

endpackage

// File: rtl/magma_cipher_core_round.sv
// One combinational Magma round; the final round skips the half swap.
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] a1,
    input  logic [31:0] a0,
    input  logic [31:0] k,
    input  logic        last,
    output logic [31:0] a1_n,
    output logic [31:0] a0_n
);

    logic [31:0] mix;

    assign mix  = magma_g(a0, k) ^ a1;
    assign a1_n = last ? mix : a0;
    assign a0_n = last ? a0  : mix;

endmodule

// File: rtl/magma_cipher_core.sv
// Iterative Magma encrypt/decrypt core with valid/ready handshake on both sides;
// ROUNDS_PER_CYCLE chained rounds are evaluated each clock.
module magma_cipher_core
    import magma_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_block,
    input  logic [255:0] in_key,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block
);

    localparam int         NUM_CYCLES = ROUNDS / ROUNDS_PER_CYCLE;
    localparam logic [4:0] LAST       = 5'(NUM_CYCLES - 1);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_param
        $error("magma_cipher_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    magma_state_e state, state_n;
    logic [4:0]   cnt;
    logic [255:0] key_r;
    logic         dec_r;
    logic [31:0]  a1_r, a0_r;
    logic [63:0]  out_r;
    logic         accept;
    logic         last_cyc;
    logic [31:0]  fin_a1, fin_a0;

    assign accept   = in_valid && in_ready;
    assign last_cyc = (cnt == LAST);

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [31:0] a1_i, a0_i, a1_o, a0_o, rk;
        logic [4:0]  ridx;
        logic [2:0]  kidx;

        if (j == 0) begin : g_first
            assign a1_i = a1_r;
            assign a0_i = a0_r;
        end else begin : g_next
            assign a1_i = g_round[j-1].a1_o;
            assign a0_i = g_round[j-1].a0_o;
        end

        assign ridx = 5'(int'(cnt) * ROUNDS_PER_CYCLE + j);
        assign kidx = magma_key_idx(ridx, dec_r);
        assign rk   = key_r[(7 - int'(kidx)) * 32 +: 32];

        magma_round u_round (
            .a1   (a1_i),
            .a0   (a0_i),
            .k    (rk),
            .last (ridx == 5'd31),
            .a1_n (a1_o),
            .a0_n (a0_o)
        );
    end

    assign fin_a1 = g_round[ROUNDS_PER_CYCLE-1].a1_o;
    assign fin_a0 = g_round[ROUNDS_PER_CYCLE-1].a0_o;

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last_cyc) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_n = in_valid ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            key_r <= '0;
            dec_r <= 1'b0;
            out_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt   <= '0;
                key_r <= in_key;
                dec_r <= in_decrypt;
            end else if (state == RUN && !last_cyc) begin
                cnt <= cnt + 5'd1;
            end
            // The visible result only moves when a new block finishes, so it holds through DONE.
            if (state == RUN && last_cyc) out_r <= {fin_a1, fin_a0};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            {a1_r, a0_r} <= in_block;
        end else if (state == RUN) begin
            {a1_r, a0_r} <= {fin_a1, fin_a0};
        end
    end

    assign out_block = out_r;

endmodule

// File: tb/tb_magma_cipher_core.sv
// Self-checking bench for magma_cipher_core: six instances (1..32 rounds per clock)
// compared against a plain behavioural Magma model.
module tb_magma_cipher_core;

    localparam logic [63:0]  PT  = 64'hfedcba9876543210;
    localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;
    localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   iv, ordy;
    logic [5:0]   ir, ov;
    logic [63:0]  ob [6];
    logic [63:0]  blk;
    logic [255:0] key;
    logic         dec;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        magma_cipher_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_block   (blk),
            .in_key     (key),
            .in_decrypt (dec),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_block  (ob[g])
        );
    end

    // Substitution boxes pi0..pi7 as listed in the standard.
    int pi [8][16] = '{
        '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
        '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
        '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
        '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
        '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
        '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
        '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
        '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
    };

    function automatic logic [31:0] g_ref(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] s, t;
        s = x + k;
        t = 0;
        for (int n = 0; n < 8; n++)
            t = t | (32'(pi[n][(s >> (4*n)) & 32'hf]) << (4*n));
        return (t << 11) | (t >> 21);
    endfunction

    function automatic logic [63:0] magma_ref(input logic [63:0] b, input logic [255:0] k, input logic d);
        int          sched [32];
        logic [31:0] a1, a0, rk, t;
        for (int i = 0; i < 24; i++) sched[i] = i % 8;
        for (int i = 24; i < 32; i++) sched[i] = 31 - i;
        a1 = b[63:32];
        a0 = b[31:0];
        for (int i = 0; i < 32; i++) begin
            rk = 32'(k >> (32 * (7 - (d ? sched[31-i] : sched[i]))));
            t  = g_ref(a0, rk) ^ a1;
            if (i == 31) return {t, a0};
            a1 = a0;
            a0 = t;
        end
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic run_block(input int d, input logic [63:0] b, input logic [255:0] k, input logic dcr,
                             output logic [63:0] res, output int lat);
        int t;
        res = '0;
        lat = 0;
        blk = b;
        key = k;
        dec = dcr;
        iv[d] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ir[d] && t < 200) begin @(negedge clk); t++; end
        if (!ir[d]) begin timeout("in_ready"); iv[d] = 1'b0; return; end
        @(posedge clk);
        #1 iv[d] = 1'b0;
        @(negedge clk);
        while (!ov[d] && lat < 200) begin lat++; @(negedge clk); end
        if (!ov[d]) begin timeout("out_valid"); return; end
        res = ob[d];
        @(posedge clk);
        #1;
    endtask

    logic [63:0]  res, ct;
    int           lat, t;
    logic [63:0]  bb_blk [4];
    logic [255:0] bb_key [4];
    logic         bb_dec [4];
    logic [63:0]  bb_res [4];
    int           acc_c [4];
    int           done_c [4];
    logic [255:0] rk;
    logic [63:0]  rb;

    initial begin
        iv = '0; ordy = '1; blk = '0; key = '0; dec = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 6; d++) begin
            chk($sformatf("reset_out_valid_r%0d", 1 << d), 64'(ov[d]), 64'd0);
            chk($sformatf("reset_in_ready_r%0d", 1 << d), 64'(ir[d]), 64'd1);
            chk($sformatf("reset_out_block_r%0d", 1 << d), ob[d], 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer vector in both directions for every rounds-per-cycle setting.
        for (int d = 0; d < 6; d++) begin
            run_block(d, PT, KEY, 1'b0, res, lat);
            chk($sformatf("kat_enc_r%0d", 1 << d), res, CT);
            chk($sformatf("kat_enc_latency_r%0d", 1 << d), 64'(lat), 64'(32 >> d));
            run_block(d, CT, KEY, 1'b1, res, lat);
            chk($sformatf("kat_dec_r%0d", 1 << d), res, PT);
            chk($sformatf("kat_dec_latency_r%0d", 1 << d), 64'(lat), 64'(32 >> d));
        end

        // Backpressure: result held, new request stalls until out_ready returns.
        ordy[0] = 1'b0;
        blk = PT; key = KEY; dec = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!ov[0] && t < 100) begin @(negedge clk); t++; end
        if (!ov[0]) timeout("bp_out_valid");
        blk = CT; key = KEY; dec = 1'b1; iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_block_%0d", i), ob[0], CT);
            chk($sformatf("bp_in_ready_low_%0d", i), 64'(ir[0]), 64'd0);
            chk($sformatf("bp_out_valid_high_%0d", i), 64'(ov[0]), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_with_out_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!ov[0] && lat < 200) begin lat++; @(negedge clk); end
        chk("bp_second_result", ob[0], PT);
        chk("bp_second_latency", 64'(lat), 64'd32);
        @(posedge clk);
        #1;

        // Back-to-back stream of alternating directions with out_ready held high.
        for (int b = 0; b < 4; b++) begin
            bb_blk[b] = {$urandom, $urandom};
            for (int w = 0; w < 8; w++) bb_key[b][32*w +: 32] = $urandom;
            bb_dec[b] = 1'(b % 2);
        end
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    int tw;
                    blk = bb_blk[b]; key = bb_key[b]; dec = bb_dec[b]; iv[0] = 1'b1;
                    tw = 0;
                    @(negedge clk);
                    while (!ir[0] && tw < 100) begin @(negedge clk); tw++; end
                    if (!ir[0]) timeout("b2b_in_ready");
                    @(posedge clk);
                    #1 acc_c[b] = cyc;
                end
                iv[0] = 1'b0;
            end
            begin
                for (int b = 0; b < 4; b++) begin
                    int tm;
                    tm = 0;
                    @(negedge clk);
                    while (!ov[0] && tm < 100) begin @(negedge clk); tm++; end
                    if (!ov[0]) timeout("b2b_out_valid");
                    done_c[b] = cyc;
                    bb_res[b] = ob[0];
                    @(posedge clk);
                end
            end
        join
        #1;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("b2b_result_%0d", b), bb_res[b], magma_ref(bb_blk[b], bb_key[b], bb_dec[b]));
            chk($sformatf("b2b_latency_%0d", b), 64'(done_c[b] - acc_c[b]), 64'd32);
            if (b > 0) chk($sformatf("b2b_no_bubble_%0d", b), 64'(acc_c[b]), 64'(done_c[b-1] + 1));
        end

        // Asynchronous reset in the middle of a computation.
        blk = PT; key = KEY; dec = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset_out_valid", 64'(ov[0]), 64'd0);
        chk("midrun_reset_in_ready", 64'(ir[0]), 64'd1);
        chk("midrun_reset_out_block", ob[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_block(0, PT, KEY, 1'b0, res, lat);
        chk("after_reset_result", res, CT);
        chk("after_reset_latency", 64'(lat), 64'd32);

        // Random round trips spread over all instances.
        for (int i = 0; i < 1000; i++) begin
            rb = {$urandom, $urandom};
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
            run_block(i % 6, rb, rk, 1'b0, ct, lat);
            chk($sformatf("rand_enc_%0d", i), ct, magma_ref(rb, rk, 1'b0));
            run_block(i % 6, ct, rk, 1'b1, res, lat);
            chk($sformatf("rand_roundtrip_%0d", i), res, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
